// File: rtl/counter_checker.sv
// counter_checker: locks onto a sampled +1 counter stream, flags deviations, wraps and source resets,
// and keeps a saturating error count.
module counter_checker #(
    parameter int COUNTER_WIDTH    = 32,
    parameter int INIT_VALUE       = 0,
    parameter int LOCK_THRESHOLD   = 4,
    parameter int RESYNC_THRESHOLD = 3,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_en,
    input  logic [COUNTER_WIDTH-1:0] cnt_in,
    input  logic                     src_rst,
    input  logic                     clear_err,
    output logic                     locked,
    output logic                     mismatch,
    output logic                     wrap,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [COUNTER_WIDTH-1:0] expected
);
    localparam logic [COUNTER_WIDTH-1:0] INIT = COUNTER_WIDTH'(INIT_VALUE);
    localparam logic [7:0] LOCK_T = 8'(LOCK_THRESHOLD);
    localparam logic [7:0] RESYNC_T = 8'(RESYNC_THRESHOLD);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               good_q, good_d, bad_q, bad_d;
    logic                     locked_q, locked_d, mismatch_q, mismatch_d, wrap_q, wrap_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d, err_base;
    logic [COUNTER_WIDTH-1:0] expected_q, expected_d, nxt;
    logic                     hit;

    // On a match cnt_in equals expected, so nxt(cnt_in) serves every branch.
    always_comb begin
        hit         = cnt_in == expected_q;
        nxt         = src_rst ? INIT : cnt_in + 1'b1;
        err_base    = clear_err ? '0 : err_count_q;
        state_d     = state_q;
        good_d      = good_q;
        bad_d       = bad_q;
        locked_d    = locked_q;
        mismatch_d  = 1'b0;
        wrap_d      = 1'b0;
        err_count_d = err_base;
        expected_d  = expected_q;
        if (sample_en) begin
            expected_d = nxt;
            case (state_q)
                HUNT: begin
                    good_d  = '0;
                    state_d = VERIFY;
                end
                VERIFY: begin
                    good_d = hit ? good_q + 8'd1 : '0;
                    if (hit && good_q + 8'd1 == LOCK_T) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        bad_d    = '0;
                    end
                end
                LOCKED: begin
                    bad_d       = hit ? '0 : bad_q + 8'd1;
                    wrap_d      = hit && (&cnt_in) && !src_rst;
                    mismatch_d  = !hit;
                    err_count_d = hit || (&err_base) ? err_base : err_base + 1'b1;
                    if (!hit && bad_q + 8'd1 == RESYNC_T) begin
                        state_d  = VERIFY;
                        locked_d = 1'b0;
                        good_d   = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            wrap_q      <= 1'b0;
            err_count_q <= '0;
            expected_q  <= '0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            mismatch_q  <= mismatch_d;
            wrap_q      <= wrap_d;
            err_count_q <= err_count_d;
            expected_q  <= expected_d;
        end
    end

    assign locked    = locked_q;
    assign mismatch  = mismatch_q;
    assign wrap      = wrap_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed plan plus randomized streams on a default-sized checker and a
// narrow one (4-bit count, 2-bit errors), each compared against a behavioural model.
module tb_counter_checker;
    logic        clk = 1'b0, rst = 1'b0;
    logic        a_en = 1'b0, a_src = 1'b0, a_clr = 1'b0;
    logic [31:0] a_cnt = '0;
    logic        a_locked, a_mm, a_wrap;
    logic [15:0] a_err;
    logic [31:0] a_exp;
    logic        b_en = 1'b0, b_src = 1'b0, b_clr = 1'b0;
    logic [3:0]  b_cnt = '0;
    logic        b_locked, b_mm, b_wrap;
    logic [1:0]  b_err;
    logic [3:0]  b_exp;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    counter_checker dut_a (
        .clk(clk), .rst(rst), .sample_en(a_en), .cnt_in(a_cnt), .src_rst(a_src), .clear_err(a_clr),
        .locked(a_locked), .mismatch(a_mm), .wrap(a_wrap), .err_count(a_err), .expected(a_exp)
    );

    counter_checker #(
        .COUNTER_WIDTH(4), .INIT_VALUE(21), .LOCK_THRESHOLD(2), .RESYNC_THRESHOLD(255), .ERR_CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .sample_en(b_en), .cnt_in(b_cnt), .src_rst(b_src), .clear_err(b_clr),
        .locked(b_locked), .mismatch(b_mm), .wrap(b_wrap), .err_count(b_err), .expected(b_exp)
    );

    typedef struct {
        bit hunt; bit lk; longint unsigned exp; int good; int bad; longint unsigned err; bit mm; bit wr;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, bit r, bit en, longint unsigned c, bit s, bit clr,
                                   int cw, int ew, int lt, int rt, longint unsigned init);
        longint unsigned mask = (64'd1 << cw) - 1;
        longint unsigned emax = (64'd1 << ew) - 1;
        m.mm = 0;
        m.wr = 0;
        if (r) begin
            m.hunt = 1; m.lk = 0; m.exp = 0; m.good = 0; m.bad = 0; m.err = 0;
            return m;
        end
        if (clr) m.err = 0;
        if (!en) return m;
        if (m.hunt) begin
            m.hunt = 0;
            m.good = 0;
        end else if (!m.lk) begin
            m.good = (c == m.exp) ? m.good + 1 : 0;
            if (m.good == lt) begin
                m.lk = 1;
                m.bad = 0;
            end
        end else if (c == m.exp) begin
            m.bad = 0;
            m.wr = (c == mask) && !s;
        end else begin
            m.mm = 1;
            m.err = (m.err < emax) ? m.err + 1 : emax;
            m.bad++;
            if (m.bad == rt) begin
                m.lk = 0;
                m.good = 0;
            end
        end
        m.exp = s ? (init & mask) : ((c + 1) & mask);
        return m;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic check_all();
        chk("a_locked", 64'(a_locked), 64'(ma.lk));
        chk("a_mismatch", 64'(a_mm), 64'(ma.mm));
        chk("a_wrap", 64'(a_wrap), 64'(ma.wr));
        chk("a_err", 64'(a_err), ma.err);
        chk("a_expected", 64'(a_exp), ma.exp);
        chk("b_locked", 64'(b_locked), 64'(mb.lk));
        chk("b_mismatch", 64'(b_mm), 64'(mb.mm));
        chk("b_wrap", 64'(b_wrap), 64'(mb.wr));
        chk("b_err", 64'(b_err), mb.err);
        chk("b_expected", 64'(b_exp), mb.exp);
    endtask

    task automatic step(bit r, bit ae, logic [31:0] ac, bit as, bit acl,
                        bit be, logic [3:0] bc, bit bs, bit bcl);
        rst = r; a_en = ae; a_cnt = ac; a_src = as; a_clr = acl;
        b_en = be; b_cnt = bc; b_src = bs; b_clr = bcl;
        @(posedge clk);
        ma = mstep(ma, r, ae, 64'(ac), as, acl, 32, 16, 4, 3, 0);
        mb = mstep(mb, r, be, 64'(bc), bs, bcl, 4, 2, 2, 255, 21);
        #1;
        check_all();
    endtask

    task automatic sa(logic [31:0] c, bit s = 0, bit cl = 0);
        step(0, 1, c, s, cl, 0, '0, 0, 0);
    endtask

    task automatic sb(logic [3:0] c, bit s = 0);
        step(0, 0, '0, 0, 0, 1, c, s, 0);
    endtask

    initial begin
        step(1, 0, '0, 0, 0, 0, '0, 0, 0);
        chk("rst_locked", 64'(a_locked), 64'd0);
        chk("rst_expected", 64'(a_exp), 64'd0);
        for (int i = 0; i < 5; i++) begin
            sa(i);
            if (i == 3) chk("t1_not_locked", 64'(a_locked), 64'd0);
        end
        chk("t1_locked", 64'(a_locked), 64'd1);
        chk("t1_expected", 64'(a_exp), 64'd5);
        sa(5); sa(6); sa(10);
        chk("t2_pulse", 64'(a_mm), 64'd1);
        sa(11); sa(12);
        chk("t2_err", 64'(a_err), 64'd1);
        chk("t2_expected", 64'(a_exp), 64'd13);
        sa(20); sa(20); sa(20);
        chk("t3_unlocked", 64'(a_locked), 64'd0);
        chk("t3_err", 64'(a_err), 64'd4);
        for (int i = 21; i <= 24; i++) sa(i);
        chk("t3_relocked", 64'(a_locked), 64'd1);
        step(1, 0, '0, 0, 0, 0, '0, 0, 0);
        for (int i = 5; i <= 9; i++) sa(i);
        sa(10, 1);
        chk("t5_src_cmp", 64'(a_mm), 64'd0);
        sa(0);
        chk("t5_src_next", 64'(a_mm), 64'd0);
        sa(1); sa(2); sa(0);
        chk("t5_no_src", 64'(a_mm), 64'd1);
        chk("t5_err", 64'(a_err), 64'd1);
        sa(7);
        sa(7, 0, 1);
        chk("clr_with_mm", 64'(a_err), 64'd1);
        step(0, 0, '0, 0, 1, 0, '0, 0, 0);
        chk("clr_alone", 64'(a_err), 64'd0);
        for (int i = 8; i <= 11; i++) sa(i);
        chk("pre_rst_locked", 64'(a_locked), 64'd1);
        step(1, 0, '0, 0, 0, 0, '0, 0, 0);
        chk("mid_rst_locked", 64'(a_locked), 64'd0);
        sb(10); sb(11); sb(12); sb(13); sb(14); sb(15);
        chk("t4_wrap", 64'(b_wrap), 64'd1);
        sb(0);
        chk("t4_wrap_once", 64'(b_wrap), 64'd0);
        sb(1);
        chk("t4_expected", 64'(b_exp), 64'd2);
        for (int i = 0; i < 5; i++) sb(9);
        chk("sat_err", 64'(b_err), 64'd3);
        chk("sat_locked", 64'(b_locked), 64'd1);
        sb(10, 1);
        chk("init_trunc", 64'(b_exp), 64'd5);
        for (int i = 0; i < 600; i++) begin
            int ra, rb;
            logic [31:0] ca;
            logic [3:0] cb;
            ra = $urandom_range(0, 9);
            rb = $urandom_range(0, 9);
            ca = ra < 8 ? 32'(ma.exp) : $urandom;
            cb = rb < 8 ? 4'(mb.exp) : 4'($urandom);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, ca, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, cb, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
